nn_job_arbiter: RTL and testbench
=================================

# nn_job_arbiter

Front-end scheduler that shares one `nn` inference core between two independent requesters. After reset it waits for the core's ROM weight-load phase to finish, then accepts jobs over valid/ready, chooses between requesters round-robin, and drives a single-cycle `enable` pulse with held operands into the core. It times the core's fixed pipeline latency, captures `final_output` and the flags, and returns them to the requester that issued the job. It sits between system-level clients and the `nn` instance and is the only agent allowed to drive `nn.enable`.

## Interface
- `DATAWIDTH`, 32: operand and result width, signed two's complement.
- `LOAD_WAIT`, 10: cycles after reset release before the first job may be accepted; covers the core's weight-load phase.
- `NN_LATENCY`, 5: clock edges after the edge on which the core samples `enable` until `final_output` is valid.
- `IDLE_GAP`, 2: cooldown cycles after each response handshake before the next accept.

- `clk` in 1: single clock; everything is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: job request.
- `req0_ready` / `req1_ready` out 1: job accepted on an edge where `valid && ready`.
- `req0_in1`, `req0_in2`, `req1_in1`, `req1_in2` in DATAWIDTH: job operands.
- `rsp0_valid` / `rsp1_valid` out 1: result available.
- `rsp0_ready` / `rsp1_ready` in 1: result consumed on an edge where `valid && ready`.
- `rsp_data` out DATAWIDTH: captured `final_output`, shared by both response ports.
- `rsp_ovf`, `rsp_zero` out 1: captured `total_ovf` and `total_zero`.
- `nn_enable` out 1: enable into the core.
- `nn_input_1`, `nn_input_2` out DATAWIDTH: operands into the core.
- `nn_final_output` in DATAWIDTH; `nn_total_ovf`, `nn_total_zero` in 1: outputs from the core.
- `busy` out 1: high in any state other than IDLE.
- `jobs_done` out 16: count of completed response handshakes; wraps.
- `ovf_count` out 16: count of completed jobs with `rsp_ovf=1`; wraps.

## Operation
- States: WAIT_LOAD, IDLE, ISSUE, BUSY, RESP, GAP.
- WAIT_LOAD: a counter runs `LOAD_WAIT` cycles, then the block moves to IDLE. Both `req*_ready` are 0 in this state.
- IDLE arbitration:
  - If any `req*_valid` is high, `grant` is chosen combinationally and only `req<grant>_ready` = 1.
  - If both requesters are valid, the grant goes to the one not recorded in `last_grant`.
  - On accept, the operands are latched into the `nn_input_*` registers, `grant` is stored, and the block moves to ISSUE.
- ISSUE: `nn_enable`=1 for exactly this one cycle. A counter is loaded with `NN_LATENCY` and the block moves to BUSY.
- BUSY: the counter decrements each edge. On the edge where it reads 0, the block captures `nn_final_output`, `nn_total_ovf` and `nn_total_zero` into the `rsp_*` registers and moves to RESP.
- RESP:
  - `rsp<grant>_valid`=1; the other response valid stays 0.
  - The block holds until `rsp<grant>_ready`. On that handshake: `last_grant`←`grant`, `jobs_done`+1, `ovf_count`+1 if `rsp_ovf`, then the block moves to GAP.
- GAP: waits `IDLE_GAP` cycles, then returns to IDLE.
- `nn_input_*` hold the latched operands from accept until the next accept. Requester operand changes after accept are ignored.
- `rsp_data`/`rsp_ovf`/`rsp_zero` hold their value until the next capture.
- Reset values:
  - All outputs are 0, `last_grant`=1 (so req0 wins first), and the state is WAIT_LOAD.
  - Reset mid-job drops the job; no response is issued. The core shares `resetn` and reloads its weights, so the block re-enters WAIT_LOAD.

## Timing
- Accept on edge E0 → ISSUE during cycle E0..E1 → the core samples enable at E1 → capture at E1+NN_LATENCY+1 (edge E0+7 with defaults) → `rsp_valid` is high from E0+7.
- Minimum spacing between consecutive accepts with immediate `rsp_ready` = 7 + 1 + `IDLE_GAP` = 10 cycles.
- First possible accept is at edge `LOAD_WAIT` after `resetn` rises.
- `req_ready` depends combinationally on `req_valid` in IDLE only; no combinational path exists from `rsp_ready` to any output.
- `rsp_ready` held low keeps the block in RESP indefinitely; the other requester stalls with ready=0.
- `rsp_ready` high before `rsp_valid` is legal and takes no effect until RESP.
- Counters wrap 0xFFFF→0x0000 silently.

## Test plan
- `req0_valid` held from reset release, in1=100, in2=-50 → `req0_ready` first high in the cycle before edge 10; one `nn_enable` pulse; `rsp0_valid` at accept+7; `rsp_data` equals the bench golden nn(100,-50); `jobs_done`=1.
- `req0_valid` and `req1_valid` both asserted in IDLE with `rsp_ready` tied high → service order req0, req1, req0, req1; each `rsp_data` matches its own operands; accepts are 10 cycles apart.
- req1 in1=0x7FFFFFFF, in2=0x30000000 → `rsp1_valid` with `rsp_data`=0xFFFFFFFF, `rsp_ovf`=1, `ovf_count`=1.
- `rsp0_ready` held low for 20 cycles with `req1_valid` high → `rsp0_valid` stays high with stable data; `req1_ready`=0 throughout; after `rsp0_ready`, req1 is accepted 3 cycles later.
- `resetn` pulsed low during BUSY → all outputs go to 0 asynchronously; no `rsp_valid`; the next accept comes `LOAD_WAIT` cycles after release and returns the correct result.
- Requester changes in1/in2 the cycle after accept → `nn_input_*` unchanged and the result matches the original operands.

Source files
------------

// File: rtl/nn_job_arbiter.sv
// Round-robin front end that shares one nn core between two requesters:
// waits out the core's weight load, issues one job at a time, returns results.
module nn_job_arbiter #(
  parameter int DATAWIDTH  = 32,
  parameter int LOAD_WAIT  = 10,
  parameter int NN_LATENCY = 5,
  parameter int IDLE_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_in1,
  input  logic [DATAWIDTH-1:0] req0_in2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_in1,
  input  logic [DATAWIDTH-1:0] req1_in2,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_ovf,
  output logic                 rsp_zero,
  output logic                 nn_enable,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  output logic                 busy,
  output logic [15:0]          jobs_done,
  output logic [15:0]          ovf_count
);

  localparam int CW = 16;
  // Wait and gap counts include the one IDLE cycle in which the accept happens.
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_WAIT - 1);
  localparam logic [CW-1:0] GAP_INIT  = CW'(IDLE_GAP - 1);
  localparam logic [CW-1:0] LAT_INIT  = CW'(NN_LATENCY);

  typedef enum logic [2:0] {
    S_WAIT_LOAD,
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic                 any_valid, grant, accept, rsp_hs, capture;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [DATAWIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 ovf_q, ovf_d, zero_q, zero_d;
  logic [15:0]          jobs_q, jobs_d, ovfc_q, ovfc_d;
  logic                 busy_q, busy_d;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    accept    = (state_q == S_IDLE) & any_valid;
    rsp_hs    = (state_q == S_RESP) & (grant_q ? rsp1_ready : rsp0_ready);
    capture   = (state_q == S_BUSY) & (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_WAIT_LOAD;
      cnt_q        <= LOAD_INIT;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in1_q        <= '0;
      in2_q        <= '0;
      data_q       <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      jobs_q       <= '0;
      ovfc_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      data_q       <= data_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      jobs_q       <= jobs_d;
      ovfc_q       <= ovfc_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_LOAD: if (cnt_q <= CW'(1)) state_d = S_IDLE;
      S_IDLE:      if (any_valid) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_BUSY;
      S_BUSY:      if (cnt_q == '0) state_d = S_RESP;
      S_RESP:      if (rsp_hs) state_d = (IDLE_GAP > 1) ? S_GAP : S_IDLE;
      S_GAP:       if (cnt_q <= CW'(1)) state_d = S_IDLE;
      default:     state_d = S_WAIT_LOAD;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    data_d       = data_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    jobs_d       = jobs_q;
    ovfc_d       = ovfc_q;
    busy_d       = (state_d != S_IDLE);

    case (state_q)
      S_WAIT_LOAD, S_GAP, S_BUSY: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      S_ISSUE:                    cnt_d = LAT_INIT;
      S_RESP:                     if (rsp_hs) cnt_d = GAP_INIT;
      default:                    cnt_d = cnt_q;
    endcase

    if (accept) begin
      grant_d = grant;
      in1_d   = grant ? req1_in1 : req0_in1;
      in2_d   = grant ? req1_in2 : req0_in2;
    end

    if (capture) begin
      data_d = nn_final_output;
      ovf_d  = nn_total_ovf;
      zero_d = nn_total_zero;
    end

    if (rsp_hs) begin
      last_grant_d = grant_q;
      jobs_d       = jobs_q + 16'd1;
      if (ovf_q) ovfc_d = ovfc_q + 16'd1;
    end
  end

  always_comb begin
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
    nn_enable  = (state_q == S_ISSUE);
    rsp0_valid = (state_q == S_RESP) & ~grant_q;
    rsp1_valid = (state_q == S_RESP) & grant_q;
    nn_input_1 = in1_q;
    nn_input_2 = in2_q;
    rsp_data   = data_q;
    rsp_ovf    = ovf_q;
    rsp_zero   = zero_q;
    busy       = busy_q;
    jobs_done  = jobs_q;
    ovf_count  = ovfc_q;
  end

endmodule

// File: tb/tb_nn_job_arbiter.sv
// Scoreboard bench for nn_job_arbiter with a fixed-latency saturating-adder core stand-in.
module tb_nn_job_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_ovf, rsp_zero, nn_enable;
  logic [31:0] nn_input_1, nn_input_2, nn_fo;
  logic        nn_ov, nn_z, busy;
  logic [15:0] jobs_done, ovf_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nn_job_arbiter #(.DATAWIDTH(32), .LOAD_WAIT(10), .NN_LATENCY(5), .IDLE_GAP(2)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .nn_enable(nn_enable), .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
    .nn_final_output(nn_fo), .nn_total_ovf(nn_ov), .nn_total_zero(nn_z),
    .busy(busy), .jobs_done(jobs_done), .ovf_count(ovf_count)
  );

  // Core stand-in: signed add, all-ones on overflow; output is only valid for
  // the single cycle five edges after enable is sampled, garbage otherwise.
  function automatic logic [33:0] nn_fn(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return {1'b1, 1'b0, 32'hFFFF_FFFF};
    return {1'b0, (s[31:0] == 32'd0), s[31:0]};
  endfunction

  logic [4:0]  pv;
  logic [31:0] pa [5];
  logic [31:0] pb [5];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv    <= '0;
      nn_fo <= '0;
      nn_ov <= 1'b0;
      nn_z  <= 1'b0;
    end else begin
      pv    <= {pv[3:0], nn_enable};
      pa[0] <= nn_input_1;
      pb[0] <= nn_input_2;
      for (int i = 1; i < 5; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
      if (pv[4]) {nn_ov, nn_z, nn_fo} <= nn_fn(pa[4], pb[4]);
      else       {nn_ov, nn_z, nn_fo} <= {1'b1, 1'b1, 32'hDEAD_BEEF};
    end
  end

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   acc_q0[$];
  int   acc_q1[$];
  int   log_id[$];
  int   log_edge[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic       pv0, pv1, acc_prev, hs_prev;
  logic [1:0] cur_ovf;
  int         exp_jobs, exp_ovf, en_cnt;

  task automatic check_rsp(input int id);
    exp_t e;
    int   a;
    logic have_e, have_a;
    have_e = 1'b0;
    have_a = 1'b0;
    chk("rsp_exclusive", 64'(id == 0 ? rsp1_valid : rsp0_valid), 64'(0));
    if (id == 0 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have_e = 1'b1; end
    if (id == 1 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have_e = 1'b1; end
    if (id == 0 && acc_q0.size() != 0) begin a = acc_q0.pop_front(); have_a = 1'b1; end
    if (id == 1 && acc_q1.size() != 0) begin a = acc_q1.pop_front(); have_a = 1'b1; end
    if (!have_e || !have_a) begin
      checks++;
      errors++;
      $display("FAIL rsp%0d_unexpected: response with no job outstanding, rsp_data=%h", id, rsp_data);
    end else begin
      chk($sformatf("rsp%0d_data", id), 64'(rsp_data), 64'(e.d));
      chk($sformatf("rsp%0d_ovf", id), 64'(rsp_ovf), 64'(e.ovf));
      chk($sformatf("rsp%0d_zero", id), 64'(rsp_zero), 64'(e.zero));
      chk($sformatf("rsp%0d_latency", id), 64'(cyc), 64'(a + 7));
      cur_ovf[id] = e.ovf;
    end
  endtask

  // Monitor: accepts, enable pulse, responses and counters, all mid-cycle.
  initial begin
    pv0 = 0; pv1 = 0; acc_prev = 0; hs_prev = 0; cur_ovf = '0;
    exp_jobs = 0; exp_ovf = 0; en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pv0 = 0; pv1 = 0; acc_prev = 0; hs_prev = 0; exp_jobs = 0; exp_ovf = 0;
      end else begin
        if (nn_enable || acc_prev) chk("nn_enable_pulse", 64'(nn_enable), 64'(acc_prev));
        if (nn_enable) en_cnt++;
        if (hs_prev) begin
          chk("jobs_done", 64'(jobs_done), 64'(exp_jobs & 16'hFFFF));
          chk("ovf_count", 64'(ovf_count), 64'(exp_ovf & 16'hFFFF));
        end
        acc_prev = 0;
        if (req0_valid && req0_ready) begin
          acc_q0.push_back(cyc + 1); log_id.push_back(0); log_edge.push_back(cyc + 1); acc_prev = 1;
        end
        if (req1_valid && req1_ready) begin
          acc_q1.push_back(cyc + 1); log_id.push_back(1); log_edge.push_back(cyc + 1); acc_prev = 1;
        end
        if (rsp0_valid && !pv0) check_rsp(0);
        if (rsp1_valid && !pv1) check_rsp(1);
        hs_prev = 0;
        if (rsp0_valid && rsp0_ready) begin hs_prev = 1; exp_jobs++; if (cur_ovf[0]) exp_ovf++; end
        if (rsp1_valid && rsp1_ready) begin hs_prev = 1; exp_jobs++; if (cur_ovf[1]) exp_ovf++; end
        pv0 = rsp0_valid;
        pv1 = rsp1_valid;
      end
    end
  end

  task automatic present(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic o, input logic z);
    exp_t e;
    e.d = d; e.ovf = o; e.zero = z;
    if (id == 0) begin
      req0_in1 = a; req0_in2 = b; req0_valid = 1'b1; exp_q0.push_back(e);
    end else begin
      req1_in1 = a; req1_in2 = b; req1_valid = 1'b1; exp_q1.push_back(e);
    end
  endtask

  task automatic wait_acc(input int id, output int e);
    e = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_valid && req0_ready) || (id == 1 && req1_valid && req1_ready)) begin
        e = cyc + 1;
        break;
      end
    end
    if (e < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req%0d not accepted within 300 cycles", id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !rsp0_valid && !rsp1_valid && exp_q0.size() == 0 && exp_q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: block not idle with empty scoreboard within 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  int e, e0, e1, rel, c, bad;

  initial begin
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset values, with req0 already requesting.
    present(0, 32'd100, -32'sd50, 32'd50, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_req0_ready", 64'(req0_ready), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_nn_enable", 64'(nn_enable), 64'(0));
    chk("reset_rsp0_valid", 64'(rsp0_valid), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    chk("reset_jobs_done", 64'(jobs_done), 64'(0));
    chk("reset_nn_input_1", 64'(nn_input_1), 64'(0));

    // First job after weight load.
    @(posedge clk); #1;
    resetn = 1'b1;
    rel = cyc;
    wait_acc(0, e);
    req0_valid = 1'b0;
    chk("t1_first_accept_edge", 64'(e - rel), 64'(10));
    wait_idle();
    chk("t1_jobs_done", 64'(jobs_done), 64'(1));
    chk("t1_enable_pulses", 64'(en_cnt), 64'(1));

    // Overflowing job on req1.
    present(1, 32'h7FFF_FFFF, 32'h3000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_acc(1, e);
    req1_valid = 1'b0;
    wait_idle();
    chk("t3_ovf_count", 64'(ovf_count), 64'(1));
    chk("t3_jobs_done", 64'(jobs_done), 64'(2));

    // Both requesters contending with responses always consumed.
    log_id.delete();
    log_edge.delete();
    present(0, 32'd1000, 32'd234, 32'd1234, 1'b0, 1'b0);
    present(1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
    fork
      begin
        wait_acc(0, e0);
        present(0, -32'sd5, 32'd5, 32'd0, 1'b0, 1'b1);
        wait_acc(0, e0);
        req0_valid = 1'b0;
      end
      begin
        wait_acc(1, e1);
        present(1, -32'sd100, -32'sd200, 32'hFFFF_FED4, 1'b0, 1'b0);
        wait_acc(1, e1);
        req1_valid = 1'b0;
      end
    join
    wait_idle();
    chk("t2_accept_count", 64'(log_id.size()), 64'(4));
    for (int i = 0; i < log_id.size() && i < 4; i++) begin
      chk($sformatf("t2_order_%0d", i), 64'(log_id[i]), 64'(i % 2));
      if (i > 0) chk($sformatf("t2_spacing_%0d", i), 64'(log_edge[i] - log_edge[i-1]), 64'(10));
    end
    chk("t2_jobs_done", 64'(jobs_done), 64'(6));

    // Response back-pressure on req0 while req1 waits.
    rsp0_ready = 1'b0;
    present(0, 32'd11, 32'd22, 32'd33, 1'b0, 1'b0);
    wait_acc(0, e);
    req0_valid = 1'b0;
    present(1, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp0_valid) break;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp0_valid || rsp_data !== 32'd33 || req1_ready) bad++;
    end
    chk("t4_stall_violations", 64'(bad), 64'(0));
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    c = cyc;
    wait_acc(1, e);
    req1_valid = 1'b0;
    chk("t4_accept_after_release", 64'(e - c), 64'(3));
    wait_idle();
    chk("t4_jobs_done", 64'(jobs_done), 64'(8));

    // Reset in the middle of a job.
    present(0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_acc(0, e);
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before_reset", 64'(busy), 64'(1));
    resetn = 1'b0;
    exp_q0.delete();
    acc_q0.delete();
    #1;
    chk("t5_async_busy", 64'(busy), 64'(0));
    chk("t5_async_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    chk("t5_async_nn_enable", 64'(nn_enable), 64'(0));
    chk("t5_async_rsp_data", 64'({rsp_data, rsp_ovf, rsp_zero}), 64'(0));
    chk("t5_async_counters", 64'({jobs_done, ovf_count}), 64'(0));
    chk("t5_async_nn_inputs", 64'({nn_input_1, nn_input_2}), 64'(0));
    present(0, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_ready_in_reset", 64'(req0_ready), 64'(0));
    resetn = 1'b1;
    rel = cyc;
    wait_acc(0, e);
    req0_valid = 1'b0;
    chk("t5_accept_after_reset", 64'(e - rel), 64'(10));
    wait_idle();
    chk("t5_jobs_done", 64'(jobs_done), 64'(1));

    // Operands change right after accept.
    present(0, -32'sd3, -32'sd4, 32'hFFFF_FFF9, 1'b0, 1'b0);
    wait_acc(0, e);
    req0_in1 = 32'd999;
    req0_in2 = 32'd999;
    req0_valid = 1'b0;
    #1;
    chk("t6_nn_input_1_held", 64'(nn_input_1), 64'(32'hFFFF_FFFD));
    chk("t6_nn_input_2_held", 64'(nn_input_2), 64'(32'hFFFF_FFFC));
    wait_idle();
    chk("t6_jobs_done", 64'(jobs_done), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: bench did not complete by 200000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
